// File: rtl/memory_arbiter.sv
// Two-port (instruction/data cache) arbiter for a single line-based memory.
// Round-robin on ties, one transaction in flight, WAIT phase bounded by TIMEOUT.
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int LINE_WIDTH    = 128,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     d_enable,
    input  logic                     i_op,
    input  logic                     d_op,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [ADDRESS_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0]    i_data_in,
    input  logic [LINE_WIDTH-1:0]    d_data_in,
    output logic [LINE_WIDTH-1:0]    i_data_out,
    output logic [LINE_WIDTH-1:0]    d_data_out,
    output logic                     i_data_ready,
    output logic                     d_data_ready,
    output logic                     i_memory_in_use,
    output logic                     d_memory_in_use,
    output logic                     error,
    output logic                     mem_enable,
    output logic                     mem_op_init,
    output logic                     mem_op,
    output logic                     mem_op_done,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0]    mem_data_in,
    input  logic [LINE_WIDTH-1:0]    mem_data_out,
    input  logic                     mem_data_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic          owner;       // 0 = instruction port, 1 = data port
    logic          last_grant;
    logic [CW-1:0] count;
    logic          grant_d;

    // Data port wins alone, or on a tie when the instruction port was served last.
    assign grant_d = d_enable & (~i_enable | ~last_grant);

    assign i_memory_in_use = (state != IDLE) &&  owner;
    assign d_memory_in_use = (state != IDLE) && !owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            count        <= '0;
            i_data_out   <= '0;
            d_data_out   <= '0;
            i_data_ready <= 1'b0;
            d_data_ready <= 1'b0;
            error        <= 1'b0;
            mem_enable   <= 1'b0;
            mem_op_init  <= 1'b0;
            mem_op       <= 1'b0;
            mem_op_done  <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_enable || d_enable) begin
                        owner       <= grant_d;
                        mem_op      <= grant_d ? d_op      : i_op;
                        mem_address <= grant_d ? d_address : i_address;
                        mem_data_in <= grant_d ? d_data_in : i_data_in;
                        mem_enable  <= 1'b1;
                        mem_op_init <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_op_init <= 1'b0;
                    count       <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (mem_data_ready || count == LAST) begin
                        if (mem_data_ready && mem_op) begin
                            if (owner) d_data_out <= mem_data_out;
                            else       i_data_out <= mem_data_out;
                        end
                        error        <= !mem_data_ready;
                        mem_enable   <= 1'b0;
                        mem_op_done  <= 1'b1;
                        i_data_ready <= !owner;
                        d_data_ready <= owner;
                        state        <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    mem_op_done  <= 1'b0;
                    i_data_ready <= 1'b0;
                    d_data_ready <= 1'b0;
                    error        <= 1'b0;
                    last_grant   <= owner;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized self-checking bench for memory_arbiter against a transaction-level model.
module tb_memory_arbiter;

    localparam int AW  = 12;
    localparam int LW  = 128;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_enable, d_enable, i_op, d_op;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] i_data_in, d_data_in;
    logic [LW-1:0] i_data_out, d_data_out;
    logic          i_data_ready, d_data_ready, i_memory_in_use, d_memory_in_use, error;
    logic          mem_enable, mem_op_init, mem_op, mem_op_done;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_data_in, mem_data_out;
    logic          mem_data_ready;

    memory_arbiter #(.ADDRESS_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_enable(i_enable), .d_enable(d_enable), .i_op(i_op), .d_op(d_op),
        .i_address(i_address), .d_address(d_address),
        .i_data_in(i_data_in), .d_data_in(d_data_in),
        .i_data_out(i_data_out), .d_data_out(d_data_out),
        .i_data_ready(i_data_ready), .d_data_ready(d_data_ready),
        .i_memory_in_use(i_memory_in_use), .d_memory_in_use(d_memory_in_use),
        .error(error), .mem_enable(mem_enable), .mem_op_init(mem_op_init),
        .mem_op(mem_op), .mem_op_done(mem_op_done), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_ready(mem_data_ready)
    );

    always #5 clk = ~clk;

    // Model: pending requests per port (0 = i, 1 = d), last served port, returned lines.
    logic          pend [2];
    logic          op   [2];
    logic [AW-1:0] addr [2];
    logic [LW-1:0] wdat [2];
    logic [LW-1:0] exp_out [2];
    logic          lg;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_req(input int unsigned p);
        pend[p] = 1'b1;
        op[p]   = 1'($urandom % 2);
        addr[p] = AW'($urandom);
        wdat[p] = rand_line();
    endtask

    task automatic drive_inputs();
        i_enable = pend[0]; i_op = op[0]; i_address = addr[0]; i_data_in = wdat[0];
        d_enable = pend[1]; d_op = op[1]; d_address = addr[1]; d_data_in = wdat[1];
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_inputs();
        @(posedge clk); #1;
        check("idle_mem_enable", mem_enable, 0);
        check("idle_in_use", {i_memory_in_use, d_memory_in_use}, 0);
    endtask

    // One full transaction from the IDLE edge; lat = WAIT cycle index with mem_data_ready
    // (lat >= TMO never answers and must time out); hold keeps the winner requesting.
    task automatic transact(input int unsigned lat, input bit hold, input logic [LW-1:0] line);
        logic w;
        logic aborted;
        @(negedge clk);
        drive_inputs();
        w = (pend[0] && pend[1]) ? ~lg : pend[1];
        @(posedge clk); #1;
        check("issue_mem_enable", mem_enable, 1);
        check("issue_op_init", mem_op_init, 1);
        check("issue_op", mem_op, op[w]);
        check("issue_addr", mem_address, addr[w]);
        check("issue_wdata", mem_data_in, wdat[w]);
        check("issue_i_in_use", i_memory_in_use, w);
        check("issue_d_in_use", d_memory_in_use, !w);
        @(negedge clk);
        mem_data_ready = 1'b1;           // must be ignored outside WAIT
        mem_data_out   = rand_line();
        @(posedge clk); #1;
        check("wait_op_init", mem_op_init, 0);
        check("wait_mem_enable", mem_enable, 1);
        aborted = 1'b1;
        for (int unsigned j = 0; j < TMO; j++) begin
            @(negedge clk);
            mem_data_ready = (j == lat);
            mem_data_out   = (j == lat) ? line : rand_line();
            if (w) begin d_op = ~d_op; d_address = AW'($urandom); d_data_in = rand_line(); end
            else   begin i_op = ~i_op; i_address = AW'($urandom); i_data_in = rand_line(); end
            @(posedge clk); #1;
            if (j == lat) begin aborted = 1'b0; break; end
            if (j == TMO - 1) break;
            check("wait_mem_enable", mem_enable, 1);
            check("wait_addr_stable", mem_address, addr[w]);
            check("wait_wdata_stable", mem_data_in, wdat[w]);
            check("wait_op_stable", mem_op, op[w]);
            check("wait_no_ready", {i_data_ready, d_data_ready}, 0);
        end
        if (!aborted && op[w]) exp_out[w] = line;
        check("done_i_ready", i_data_ready, !w);
        check("done_d_ready", d_data_ready, w);
        check("done_error", error, aborted);
        check("done_op_done", mem_op_done, 1);
        check("done_mem_enable", mem_enable, 0);
        check("done_addr_stable", mem_address, addr[w]);
        check("done_i_data_out", i_data_out, exp_out[0]);
        check("done_d_data_out", d_data_out, exp_out[1]);
        @(negedge clk);
        mem_data_ready = 1'($urandom % 2);
        mem_data_out   = rand_line();
        if (hold) new_req(w);
        else      pend[w] = 1'b0;
        drive_inputs();
        lg = w;
        @(posedge clk); #1;
        check("back_idle_ready", {i_data_ready, d_data_ready}, 0);
        check("back_idle_op_done", mem_op_done, 0);
        check("back_idle_error", error, 0);
        check("back_idle_mem_enable", mem_enable, 0);
        check("back_idle_in_use", {i_memory_in_use, d_memory_in_use}, 0);
    endtask

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_out[0] = '0; exp_out[1] = '0;
        lg = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin op[p] = 1'b0; addr[p] = '0; wdat[p] = '0; end
        model_reset();
        drive_inputs();
        mem_data_ready = 1'b0;
        mem_data_out   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_enable", mem_enable, 0);
        check("rst_pulses", {i_data_ready, d_data_ready, error, mem_op_init, mem_op_done}, 0);
        check("rst_i_data_out", i_data_out, 0);
        check("rst_d_data_out", d_data_out, 0);
        check("rst_mem_fields", {mem_op, mem_address, mem_data_in}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Instruction read with fastest memory response.
        new_req(0); op[0] = 1'b1; addr[0] = 12'h010;
        transact(0, 1'b0, {32'hDEADBEEF, 64'h0, 32'h0000_0001});
        // Data write with d_data_in changing during WAIT.
        new_req(1); op[1] = 1'b0; addr[1] = 12'hABC; wdat[1] = {16{8'h55}};
        transact(1, 1'b0, rand_line());
        // Memory never answers.
        new_req(0); op[0] = 1'b1;
        transact(9, 1'b0, rand_line());
        // Instruction port keeps enable high through its ready pulse.
        new_req(0);
        transact(2, 1'b1, rand_line());
        transact(0, 1'b0, rand_line());

        // Reset during WAIT.
        new_req(0); op[0] = 1'b1;
        @(negedge clk);
        drive_inputs();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_mem_enable", mem_enable, 0);
        check("midrst_in_use", {i_memory_in_use, d_memory_in_use}, 0);
        model_reset();
        drive_inputs();
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst_no_ready", {i_data_ready, d_data_ready}, 0);
        end
        check("midrst_i_data_out", i_data_out, 0);
        @(negedge clk);
        reset = 1'b1;

        // Tie right after reset: i, then d, then next tie to i again.
        new_req(0); new_req(1);
        transact(1, 1'b0, rand_line());
        transact(2, 1'b0, rand_line());
        new_req(0); new_req(1);
        transact(0, 1'b0, rand_line());
        transact(3, 1'b0, rand_line());

        for (int n = 0; n < 60; n++) begin
            if (!pend[0] && ($urandom % 2) == 0) new_req(0);
            if (!pend[1] && ($urandom % 2) == 0) new_req(1);
            if (!pend[0] && !pend[1]) begin
                idle_cycle();
                new_req($urandom % 2);
            end
            transact($urandom_range(0, TMO + 1), ($urandom % 4) == 0, rand_line());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDRESS_WIDTH, 12, line address width; LINE_WIDTH, 128, cache line width; TIMEOUT, 255, maximum WAIT cycles before abort.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 i_enable, d_enable  in  1 each  request level from instruction/data cache, held until own ready pulse.
REQ-006 i_op, d_op  in  1 each  1 = read line, 0 = write line.
REQ-007 i_address, d_address  in  ADDRESS_WIDTH each  line address.
REQ-008 i_data_in, d_data_in  in  LINE_WIDTH each  write line data.
REQ-009 i_data_out, d_data_out  out  LINE_WIDTH each  read line returned to requester.
REQ-010 i_data_ready, d_data_ready  out  1 each  one-cycle completion pulse.
REQ-011 i_memory_in_use, d_memory_in_use  out  1 each  memory busy serving another port.
REQ-012 error  out  1  one-cycle pulse on timeout abort.
REQ-013 mem_enable, mem_op_init, mem_op, mem_op_done  out  1 each  memory-side request controls.
REQ-014 mem_address  out  ADDRESS_WIDTH; mem_data_in  out  LINE_WIDTH  latched request.
REQ-015 mem_data_out  in  LINE_WIDTH; mem_data_ready  in  1  memory response.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one port owns the memory outside IDLE.
REQ-017 IDLE: at an edge with any enable high, select owner, latch owner op/address/data_in into mem_op/mem_address/mem_data_in, go ISSUE; else stay.
REQ-018 Arbitration: single requester wins; both requesting -> port not equal to last_grant wins (round-robin).
REQ-019 ISSUE (exactly one cycle): mem_enable=1, mem_op_init=1; go WAIT, clear timeout counter.
REQ-020 WAIT: mem_enable=1, mem_op_init=0, counter increments per cycle; at edge with mem_data_ready=1, capture mem_data_out into owner data_out if read, go DONE.
REQ-021 WAIT timeout: counter reaching TIMEOUT without mem_data_ready -> go DONE with abort flag; owner data_out unchanged.
REQ-022 DONE (exactly one cycle): mem_enable=0, mem_op_done=1, owner data_ready=1; error=1 only if aborted; last_grant <- owner; go IDLE.
REQ-023 Writes complete with data_ready pulse; data_out unchanged.
REQ-024 Minimum latency: enable sampled at edge k -> ISSUE cycle k+1, WAIT from k+2; mem_data_ready sampled at edge m -> data_ready high in cycle after m; best case 3 cycles.
REQ-025 x_memory_in_use = (state != IDLE) and owner != x; combinational from registered state.
REQ-026 Requester must drop enable in data_ready cycle; enable still high at next IDLE edge is a new request, subject to round-robin.
REQ-027 Latched request fields are stable from ISSUE through DONE regardless of input changes.
REQ-028 data_out holds last read value until next read completion for that port.
REQ-029 mem_data_ready outside WAIT is ignored.

Reset
REQ-030 reset low asynchronously forces IDLE; all outputs 0; data_out registers 0; counter 0; last_grant = d port (so i port wins first tie).
REQ-031 Reset mid-operation drops in-flight request without data_ready; mem_enable falls immediately, not at clock edge.
REQ-032 After reset release, first request accepted at first rising edge with reset high.

Verification
REQ-033 i read addr 0x010, memory returns 0xDEADBEEF_..._0001 with mem_data_ready the cycle after ISSUE -> mem_op_init one cycle, i_data_ready pulse 3 cycles after request, i_data_out equals line, mem_op_done coincident.
REQ-034 i and d request same edge after reset -> i served first, d_memory_in_use=1 throughout; then d served; next tie goes to i.
REQ-035 d write addr 0xABC, data 0x5555...; d_data_in changed during WAIT -> mem_data_in stays 0x5555..., d_data_ready pulse, d_data_out unchanged.
REQ-036 memory never asserts mem_data_ready, TIMEOUT=4 -> error and i_data_ready pulse after 4 WAIT cycles, FSM back to IDLE.
REQ-037 reset low during WAIT -> mem_enable 0 without clock edge, no data_ready, next request proceeds normally.
REQ-038 i_enable held through data_ready with d idle -> second i transaction starts next IDLE edge.
